code_lock_fsm: RTL and testbench
================================

# code_lock_fsm

Sequential controller downstream of `eq_comparator`. Users enter a code one 4-bit digit per cycle. For each digit, the block selects the expected code nibble (`code_idx`). The comparator's `eq` result is consumed here to decide unlock, failed attempt or lockout. The block sits between the keypad/digit-entry logic and the door/status outputs of the lab lock design.

## Interface
- `CODE_LEN`, 4, digits per attempt; legal range 2..16.
- `MAX_FAIL`, 3, consecutive failed attempts that trigger lockout; legal range 1..15.
- `UNLOCK_CYCLES`, 8, cycles `unlocked` stays high; ≥1.
- `LOCKOUT_CYCLES`, 16, cycles spent in lockout; ≥1.
- `TIMEOUT_CYCLES`, 32, idle cycles mid-entry before the partial entry is aborted; ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `digit_valid`  in  1  the current digit (comparator input `a`) is valid this cycle.
- `eq`  in  1  comparator result for the current digit vs. code nibble `code_idx`; sampled only when `digit_valid`=1.
- `code_idx`  out  4  index of the expected code nibble; it drives the mux feeding comparator input `b`.
- `unlocked`  out  1  high while in state UNLOCK.
- `locked_out`  out  1  high while in state LOCKOUT.
- `fail_cnt`  out  4  consecutive failed attempts so far.
- `attempt_done`  out  1  one-cycle pulse when an attempt completes.
- `attempt_ok`  out  1  one-cycle pulse, coincident with `attempt_done`, when that attempt matched.

## Operation
- States: ENTRY, UNLOCK, LOCKOUT. All outputs are registered.
- Reset (`rst`=1 at an edge) forces:
  - state=ENTRY.
  - `code_idx`=0, `fail_cnt`=0, `unlocked`=0, `locked_out`=0, `attempt_done`=0, `attempt_ok`=0.
  - Internal `mismatch`=0, timer=0.
- Reset overrides any state, including mid-entry, UNLOCK and LOCKOUT.

ENTRY, `digit_valid`=1, `code_idx` < CODE_LEN-1:
- `mismatch` <= `mismatch` | ~`eq`.
- `code_idx` increments.
- Idle timer clears.

ENTRY, `digit_valid`=1, `code_idx` = CODE_LEN-1 (final digit): the attempt resolves with ok = ~(`mismatch` | ~`eq`).
- On every resolution:
  - `attempt_done` pulses.
  - `attempt_ok` = ok.
  - `code_idx`<=0.
  - `mismatch`<=0.
- If ok:
  - Go to UNLOCK.
  - `fail_cnt`<=0.
- If not ok and `fail_cnt`+1 = MAX_FAIL:
  - Go to LOCKOUT.
  - `fail_cnt`<=0.
- If not ok otherwise:
  - Stay in ENTRY.
  - `fail_cnt` increments.

ENTRY idle timeout:
- The idle timer counts cycles with `digit_valid`=0 only while `code_idx`≠0.
- When it reaches TIMEOUT_CYCLES: `code_idx`<=0, `mismatch`<=0, timer cleared.
- A timeout produces no `attempt_done` and leaves `fail_cnt` unchanged.

UNLOCK:
- `digit_valid` is ignored.
- The state holds for exactly UNLOCK_CYCLES cycles, then returns to ENTRY.

LOCKOUT:
- `digit_valid` is ignored.
- The state holds for exactly LOCKOUT_CYCLES cycles, then returns to ENTRY with `fail_cnt`=0.

`eq` is don't-care whenever `digit_valid`=0 or the state is not ENTRY.

## Timing
- `code_idx` changes on the edge that accepts a digit. The upstream mux and comparator see the new index in the following cycle, so back-to-back digits every cycle are legal.
- Final-digit acceptance edge E:
  - `attempt_done`/`attempt_ok` are high in cycle E+1, for one cycle only.
  - `unlocked` or `locked_out` rises in cycle E+1.
- `unlocked` is high for UNLOCK_CYCLES consecutive cycles. In the cycle after it falls, a digit may be accepted.
- `locked_out` behaves the same way, with LOCKOUT_CYCLES.
- Timeout: if the last digit was accepted at edge T and no further digit arrives, `code_idx` reads 0 from cycle T+TIMEOUT_CYCLES+1.
- If `digit_valid`=1 arrives in the same cycle the timer reaches the limit, the digit wins: it is accepted and the timer clears.
- `rst` asserted in the same cycle as a final digit: reset wins, with no `attempt_done`.

## Test plan
- Reset mid-entry: accept 2 digits, then assert `rst` → next cycle `code_idx`=0, `fail_cnt`=0, all flags 0. A subsequent full correct entry unlocks.
- Correct code, back-to-back: 4 valid digits with `eq`=1,1,1,1 in consecutive cycles.
  - Required: `code_idx` 0→1→2→3→0.
  - Required: `attempt_done`=`attempt_ok`=1 for one cycle.
  - Required: `unlocked`=1 for exactly 8 cycles; `fail_cnt`=0.
- Single wrong digit: `eq`=1,0,1,1 → `attempt_done`=1, `attempt_ok`=0, `fail_cnt`=1, `unlocked` stays 0.
- Lockout:
  - Three wrong attempts → `fail_cnt` 1, 2, then `locked_out`=1 for 16 cycles with `fail_cnt`=0.
  - Digits pulsed during lockout are ignored (`code_idx` stays 0).
  - After lockout, a correct code unlocks.
- Timeout: accept 2 digits, then idle 32 cycles → `code_idx` returns to 0, no `attempt_done`, `fail_cnt` unchanged. A fresh correct entry then unlocks.
- Timeout/digit collision: a digit arrives exactly on the 32nd idle cycle → the digit is accepted, `code_idx` advances to 3, and no abort occurs.

Source files
------------

// File: rtl/code_lock_fsm.sv
// Code-entry lock controller: walks code_idx over the stored code, resolves attempts,
// and sequences UNLOCK / LOCKOUT hold periods. All outputs registered (1-cycle latency).
module code_lock_fsm #(
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAIL       = 3,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic       eq,
    output logic [3:0] code_idx,
    output logic       unlocked,
    output logic       locked_out,
    output logic [3:0] fail_cnt,
    output logic       attempt_done,
    output logic       attempt_ok
);

    localparam int HOLD_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(HOLD_MAX + 1);

    localparam logic [3:0]    LAST_IDX   = 4'(CODE_LEN - 1);
    localparam logic [3:0]    FAIL_LAST  = 4'(MAX_FAIL - 1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] UNL_LAST   = HW'(UNLOCK_CYCLES - 1);
    localparam logic [HW-1:0] LOCK_LAST  = HW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        UNLOCK  = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    idx_nxt, fail_nxt;
    logic          mismatch, mismatch_nxt;
    logic [TW-1:0] idle_timer, idle_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          done_nxt, ok_nxt;

    always_comb begin
        state_nxt    = state;
        idx_nxt      = code_idx;
        fail_nxt     = fail_cnt;
        mismatch_nxt = mismatch;
        idle_nxt     = idle_timer;
        hold_nxt     = hold_cnt;
        done_nxt     = 1'b0;
        ok_nxt       = 1'b0;

        case (state)
            ENTRY: begin
                if (digit_valid) begin
                    // An accepted digit always wins over a timeout in the same cycle.
                    idle_nxt = '0;
                    if (code_idx == LAST_IDX) begin
                        done_nxt     = 1'b1;
                        ok_nxt       = ~(mismatch | ~eq);
                        idx_nxt      = 4'd0;
                        mismatch_nxt = 1'b0;
                        hold_nxt     = '0;
                        if (ok_nxt) begin
                            state_nxt = UNLOCK;
                            fail_nxt  = 4'd0;
                        end else if (fail_cnt == FAIL_LAST) begin
                            state_nxt = LOCKOUT;
                            fail_nxt  = 4'd0;
                        end else begin
                            fail_nxt  = fail_cnt + 4'd1;
                        end
                    end else begin
                        mismatch_nxt = mismatch | ~eq;
                        idx_nxt      = code_idx + 4'd1;
                    end
                end else if (code_idx != 4'd0) begin
                    if (idle_timer == IDLE_LAST) begin
                        idx_nxt      = 4'd0;
                        mismatch_nxt = 1'b0;
                        idle_nxt     = '0;
                    end else begin
                        idle_nxt = idle_timer + TW'(1);
                    end
                end
            end
            UNLOCK: begin
                if (hold_cnt == UNL_LAST) begin
                    state_nxt = ENTRY;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            LOCKOUT: begin
                fail_nxt = 4'd0;
                if (hold_cnt == LOCK_LAST) begin
                    state_nxt = ENTRY;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_nxt = ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ENTRY;
            code_idx     <= 4'd0;
            fail_cnt     <= 4'd0;
            mismatch     <= 1'b0;
            idle_timer   <= '0;
            hold_cnt     <= '0;
            unlocked     <= 1'b0;
            locked_out   <= 1'b0;
            attempt_done <= 1'b0;
            attempt_ok   <= 1'b0;
        end else begin
            state        <= state_nxt;
            code_idx     <= idx_nxt;
            fail_cnt     <= fail_nxt;
            mismatch     <= mismatch_nxt;
            idle_timer   <= idle_nxt;
            hold_cnt     <= hold_nxt;
            unlocked     <= (state_nxt == UNLOCK);
            locked_out   <= (state_nxt == LOCKOUT);
            attempt_done <= done_nxt;
            attempt_ok   <= ok_nxt;
        end
    end

endmodule

// File: tb/tb_code_lock_fsm.sv
// Directed-vector bench for code_lock_fsm: table of per-edge expectations plus
// hand-written timeout, collision and reset-vs-final-digit sequences.
module tb_code_lock_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       digit_valid = 1'b0;
    logic       eq = 1'b0;
    logic [3:0] code_idx;
    logic       unlocked;
    logic       locked_out;
    logic [3:0] fail_cnt;
    logic       attempt_done;
    logic       attempt_ok;

    int total = 0;
    int bad = 0;

    code_lock_fsm #(
        .CODE_LEN(4), .MAX_FAIL(3), .UNLOCK_CYCLES(8),
        .LOCKOUT_CYCLES(16), .TIMEOUT_CYCLES(32)
    ) dut (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .eq(eq),
        .code_idx(code_idx), .unlocked(unlocked), .locked_out(locked_out),
        .fail_cnt(fail_cnt), .attempt_done(attempt_done), .attempt_ok(attempt_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, v, e;
        logic [3:0] idx;
        logic       unl, lo;
        logic [3:0] fc;
        logic       d, ok;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, v, e, input logic [3:0] idx,
                       input logic unl, lo, input logic [3:0] fc, input logic d, ok);
        vec_t t;
        t.r = r; t.v = v; t.e = e; t.idx = idx; t.unl = unl; t.lo = lo;
        t.fc = fc; t.d = d; t.ok = ok;
        vecs.push_back(t);
    endtask

    task automatic tick(input logic r, v, e);
        rst = r; digit_valid = v; eq = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {code_idx, unlocked, locked_out, fail_cnt, attempt_done, attempt_ok};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;

        // reset, then reset mid-entry
        add(1,0,0, 0,0,0,0,0,0);
        add(0,1,1, 1,0,0,0,0,0);
        add(0,1,1, 2,0,0,0,0,0);
        add(1,1,1, 0,0,0,0,0,0);
        // correct code back-to-back
        add(0,1,1, 1,0,0,0,0,0);
        add(0,1,1, 2,0,0,0,0,0);
        add(0,1,1, 3,0,0,0,0,0);
        add(0,1,1, 0,1,0,0,1,1);
        for (int i = 0; i < 7; i++) add(0,1,0, 0,1,0,0,0,0);
        add(0,0,0, 0,0,0,0,0,0);
        // digit accepted right after unlocked falls; eq=1,0,1,1
        add(0,1,1, 1,0,0,0,0,0);
        add(0,1,0, 2,0,0,0,0,0);
        add(0,1,1, 3,0,0,0,0,0);
        add(0,1,1, 0,0,0,1,1,0);
        add(0,0,0, 0,0,0,1,0,0);
        // second wrong attempt
        add(0,1,0, 1,0,0,1,0,0);
        add(0,1,0, 2,0,0,1,0,0);
        add(0,1,0, 3,0,0,1,0,0);
        add(0,1,0, 0,0,0,2,1,0);
        // third wrong attempt (only final digit wrong) -> lockout
        add(0,1,1, 1,0,0,2,0,0);
        add(0,1,1, 2,0,0,2,0,0);
        add(0,1,1, 3,0,0,2,0,0);
        add(0,1,0, 0,0,1,0,1,0);
        for (int i = 0; i < 15; i++) add(0,1,1, 0,0,1,0,0,0);
        add(0,0,0, 0,0,0,0,0,0);
        // correct code after lockout
        add(0,1,1, 1,0,0,0,0,0);
        add(0,1,1, 2,0,0,0,0,0);
        add(0,1,1, 3,0,0,0,0,0);
        add(0,1,1, 0,1,0,0,1,1);
        for (int i = 0; i < 7; i++) add(0,0,0, 0,1,0,0,0,0);
        add(0,0,0, 0,0,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].r, vecs[i].v, vecs[i].e);
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vecs[i].idx, vecs[i].unl, vecs[i].lo, vecs[i].fc, vecs[i].d, vecs[i].ok}));
        end

        // one failed attempt so the timeout can be shown to keep fail_cnt
        for (int i = 0; i < 4; i++) tick(0, 1, 0);
        chk("pre_timeout_fc", 32'(fail_cnt), 32'd1);
        tick(0, 1, 1);
        tick(0, 1, 1);
        chk("to_idx2", 32'(code_idx), 32'd2);
        saw_done = 1'b0;
        for (int i = 0; i < 31; i++) begin
            tick(0, 0, 0);
            if (attempt_done) saw_done = 1'b1;
        end
        chk("to_before_limit", 32'(code_idx), 32'd2);
        tick(0, 0, 0);
        if (attempt_done) saw_done = 1'b1;
        chk("to_abort_idx", 32'(code_idx), 32'd0);
        chk("to_no_done", 32'(saw_done), 32'd0);
        chk("to_fc_kept", 32'(fail_cnt), 32'd1);
        // fresh correct entry after timeout must not inherit stale mismatch
        for (int i = 0; i < 4; i++) tick(0, 1, 1);
        chk("to_unlock", 32'({unlocked, attempt_ok, fail_cnt}), 32'({1'b1, 1'b1, 4'd0}));
        for (int i = 0; i < 8; i++) tick(0, 0, 0);
        chk("to_unlock_end", 32'(unlocked), 32'd0);

        // digit on the 32nd idle cycle wins over the abort
        tick(0, 1, 1);
        tick(0, 1, 1);
        for (int i = 0; i < 31; i++) tick(0, 0, 0);
        tick(0, 1, 1);
        chk("col_idx3", 32'(code_idx), 32'd3);
        tick(0, 0, 0);
        chk("col_no_abort", 32'(code_idx), 32'd3);
        tick(0, 1, 1);
        chk("col_unlock", 32'({unlocked, attempt_done, attempt_ok}), 32'({1'b1, 1'b1, 1'b1}));
        for (int i = 0; i < 8; i++) tick(0, 0, 0);

        // reset coincident with final digit
        for (int i = 0; i < 3; i++) tick(0, 1, 1);
        chk("rf_idx3", 32'(code_idx), 32'd3);
        tick(1, 1, 1);
        chk("rf_reset_wins", 32'(outs()), 32'd0);
        tick(0, 0, 0);
        chk("rf_quiet", 32'({unlocked, attempt_done}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
